fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Fetch stage sitting directly downstream of the PC register and upstream of decode/rename.
- Issues one instruction-memory read per fetch PC and tracks the single outstanding request.
- Pushes {pc, inst} pairs into an internal instruction FIFO.
- Pulses request_new_inst back to the PC register to advance the PC.
- On flush, drops buffered and in-flight instructions so fetch restarts at the redirected PC.

Parameters:
DEPTH, 8, instruction FIFO entries; power of two, at least 2.

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset
pc  in  32  current fetch PC from PC register (combinational; equals pc_next while request_new_inst or flush is high)
flush  in  1  pipeline flush / redirect
request_new_inst  out  1  advance PC register; one-cycle pulse per accepted instruction
imem_addr  out  32  read address, {pc[31:2],2'b00}; don't-care while imem_rmask=0
imem_rmask  out  4  4'hF for exactly one cycle per request, else 4'h0
imem_rdata  in  32  returned instruction word
imem_resp  in  1  one-cycle response strobe, at least 1 cycle after request
out_valid  out  1  FIFO head valid
out_pc  out  32  PC of head entry
out_inst  out  32  instruction of head entry
out_ready  in  1  consumer pops head when out_valid && out_ready

Behaviour:
- Reset (rst_n=0 at posedge, synchronous):
  - state=IDLE, FIFO count=0, pointers=0.
  - request_new_inst=0, imem_rmask=0, out_valid=0, out_pc/out_inst=0.
  - Reset mid-request abandons it; a stale imem_resp arriving after reset is ignored (state IDLE).
- States:
  - IDLE: no request outstanding.
  - WAIT: request outstanding; its PC is latched in req_pc.
  - DISCARD: request outstanding but killed by flush.
- Issue condition: can_issue = !flush && (count_after_this_cycle < DEPTH), where count_after accounts for this cycle's push and pop. Only one request may be outstanding, so one reserved slot guarantees every response can be pushed.
- IDLE:
  - can_issue: imem_rmask=4'hF, imem_addr=aligned pc, req_pc<=pc, go to WAIT.
  - Otherwise stay in IDLE.
- WAIT, no imem_resp: hold; on flush go to DISCARD.
- WAIT, imem_resp && !flush:
  - Push {req_pc, imem_rdata}; request_new_inst=1 in the same cycle.
  - If can_issue, issue back-to-back in that cycle using pc (already the next PC), latch it, and stay in WAIT.
  - Otherwise go to IDLE.
- WAIT, imem_resp && flush: drop the response, request_new_inst=0, go to IDLE.
- DISCARD:
  - On imem_resp: drop the data, request_new_inst=0, go to IDLE.
  - flush while in DISCARD: remain in DISCARD.
- request_new_inst is asserted only in the WAIT+resp+!flush case; never otherwise.
- Flush, any state: FIFO count and pointers cleared at the next edge; out_valid=0 the following cycle. No push occurs in the flush cycle, and no request is issued in the flush cycle.
- FIFO:
  - Circular buffer with wrap-around pointers.
  - out_* driven combinationally from the head entry; out_valid = (count != 0).
  - Simultaneous push and pop: count unchanged. Pop on an empty FIFO is ignored.
  - A push into a full FIFO cannot occur by construction; verification asserts this.
- Latency: with a 1-cycle memory, an instruction reaches out_valid 2 cycles after imem_rmask. Sustained throughput is 1 instruction/cycle with back-to-back issue.

Test Plan:
- Reset → first fetch: hold rst_n=0 for 2 cycles, pc=0x6000_0000, release → imem_rmask=4'hF, imem_addr=0x6000_0000 in the first cycle out of reset. With a 1-cycle resp of 0x00000013 → request_new_inst pulses and out_pc=0x6000_0000, out_inst=0x00000013, out_valid=1 next cycle.
- Streaming: 1-cycle memory, out_ready=1, pc incrementing by 4 → one request per cycle after the first; out_pc sequence 0x6000_0000, 0x6000_0004, 0x6000_0008, …; request_new_inst high every cycle.
- FIFO full: out_ready=0 → exactly DEPTH=8 entries accepted, then imem_rmask stays 0. One pop → exactly one new request; count never exceeds 8.
- Flush during WAIT: request at pc=0x6000_0010, flush one cycle before resp → response dropped, no request_new_inst pulse, FIFO empty. Next request issued from missed_pc (e.g. 0x6000_0100) the cycle after the discarded resp.
- Flush coincident with resp and FIFO holding 3 entries → resp dropped, out_valid=0 next cycle, state IDLE. Next cycle a request to the new pc is issued.
- Reset mid-WAIT: assert rst_n=0 while a request is outstanding, and have resp arrive during reset → no push, no request_new_inst pulse. After release, fetch restarts cleanly from pc.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage
//   Fetch stage between the PC register and decode/rename. It issues one
//   instruction-memory read per fetch PC and keeps at most one request in
//   flight. Returned words are pushed as {pc, inst} into a small circular
//   FIFO. Each accepted instruction pulses request_new_inst so the PC register
//   advances. A flush empties the FIFO and kills any in-flight request so that
//   fetch restarts at the redirected PC.
//
// Handshake (out_*): the head entry is presented on out_pc/out_inst while
//   out_valid is high. The consumer takes it in any cycle where
//   out_valid && out_ready. out_* do not depend on out_ready.
//
// Ports
//   clk              clock; all state changes on the rising edge
//   rst_n            synchronous active-low reset
//   pc               current fetch PC (already pc_next while request_new_inst
//                    or flush is high)
//   flush            pipeline flush / redirect
//   request_new_inst one-cycle pulse per accepted instruction
//   imem_addr        word-aligned read address
//   imem_rmask       4'hF for one cycle per issued request, else 4'h0
//   imem_rdata       returned instruction word
//   imem_resp        one-cycle response strobe
//   out_valid        FIFO head valid
//   out_pc/out_inst  head entry (zero while the FIFO is empty)
//   out_ready        consumer ready
//   dbg_state        current FSM state (IDLE=0, WAIT=1, DISCARD=2)
module fetch_stage #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic        request_new_inst,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  input  logic        out_ready,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [31:0]     r_req_pc;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic [31:0]     r_pc_mem   [DEPTH];
  logic [31:0]     r_inst_mem [DEPTH];

  logic            w_push;
  logic            w_pop;
  logic            w_can_issue;
  logic            w_issue;
  logic [AW+1:0]   w_count_after;
  logic            w_unused_pc_lsb;

  assign w_unused_pc_lsb = ^pc[1:0];

  // A response is only accepted for a live (not killed) request and never in
  // a flush cycle; reset also blocks it so a stale strobe is ignored.
  assign w_push = rst_n && (r_state == S_WAIT) && imem_resp && !flush;
  assign w_pop  = out_valid && out_ready;

  // Occupancy at the end of this cycle. Issuing only when this leaves a free
  // slot reserves room for the single outstanding response, so a push can
  // never hit a full FIFO.
  assign w_count_after = {1'b0, r_count}
                       + {{(AW+1){1'b0}}, w_push}
                       - {{(AW+1){1'b0}}, w_pop};
  assign w_can_issue   = rst_n && !flush && (w_count_after < (AW+2)'(DEPTH));

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_can_issue) begin
          w_issue     = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_resp) begin
          if (flush) begin
            w_state_nxt = S_IDLE;
          end else if (w_can_issue) begin
            // Back-to-back: pc already shows the next PC this cycle.
            w_issue     = 1'b1;
            w_state_nxt = S_WAIT;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (flush) begin
          w_state_nxt = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (imem_resp) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_req_pc <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_issue) begin
        r_req_pc <= pc;
      end
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
        r_count <= w_count_after[AW:0];
      end
    end
  end

  // Storage needs no reset: entries are only visible while counted valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]   <= r_req_pc;
      r_inst_mem[r_wr_ptr] <= imem_rdata;
    end
  end

  assign request_new_inst = w_push;
  assign imem_rmask       = w_issue ? 4'hF : 4'h0;
  assign imem_addr        = {pc[31:2], 2'b00};
  assign out_valid        = (r_count != '0);
  assign out_pc           = out_valid ? r_pc_mem[r_rd_ptr]   : 32'h0;
  assign out_inst         = out_valid ? r_inst_mem[r_rd_ptr] : 32'h0;
  assign dbg_state        = r_state;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam int DEPTH = 8;

  // ---------------- clock / reset / signals ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        out_ready;
  logic        imem_resp;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] pc_reg;
  logic [31:0] redirect_pc;
  logic        request_new_inst;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  // PC register model: shows pc_next combinationally while advancing/redirecting.
  assign pc = flush ? redirect_pc : (request_new_inst ? pc_reg + 32'd4 : pc_reg);

  fetch_stage #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .flush(flush),
    .request_new_inst(request_new_inst), .imem_addr(imem_addr),
    .imem_rmask(imem_rmask), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
    .out_ready(out_ready), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];          // {pc, inst} accepted but not yet consumed
  bit          m_out;             // a request is in flight
  bit          m_killed;          // ...and a flush has killed it
  logic [31:0] m_req_addr;

  // memory responder
  bit          mem_busy;
  int          mem_cnt;
  int          lat_cfg;           // 0 = random 1..3 per request
  logic [31:0] mem_addr;

  // observation
  int          cyc, n_issue, n_pulse, n_pop, last_pop_cyc;
  logic [31:0] pop_pc_q[$];
  logic [3:0]  s_rmask;
  logic [31:0] s_addr;
  logic        s_valid;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h6000_0000) return 32'h0000_0013;
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive memory, sample mid-cycle, check, advance model.
  task automatic tick();
    logic        exp_pulse, exp_pop, exp_issue;
    int          after;
    logic [31:0] fetch_pc, nxt_pc;
    logic [63:0] head;
    logic        was_resp;
    imem_resp  = 1'b0;
    imem_rdata = 32'h0;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt <= 0) begin
        imem_resp  = 1'b1;
        imem_rdata = mem_word(mem_addr);
      end
    end
    #4;
    exp_pulse = 1'b0; exp_pop = 1'b0; exp_issue = 1'b0; fetch_pc = pc_reg;
    s_rmask = imem_rmask; s_addr = imem_addr; s_valid = out_valid;
    if (!rst_n) begin
      chk("rst_rmask", {28'h0, imem_rmask}, 32'h0);
      chk("rst_req_new_inst", {31'h0, request_new_inst}, 32'h0);
    end else begin
      exp_pulse = imem_resp && m_out && !m_killed && !flush;
      exp_pop   = (exp_q.size() != 0) && out_ready;
      after     = exp_q.size() + int'(exp_pulse) - int'(exp_pop);
      exp_issue = !flush && (!m_out || exp_pulse) && (after < DEPTH);
      fetch_pc  = exp_pulse ? pc_reg + 32'd4 : pc_reg;
      chk("out_valid", {31'h0, out_valid}, {31'h0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
        head = exp_q[0];
        chk("out_pc", out_pc, head[63:32]);
        chk("out_inst", out_inst, head[31:0]);
      end
      chk("req_new_inst", {31'h0, request_new_inst}, {31'h0, exp_pulse});
      chk("imem_rmask", {28'h0, imem_rmask}, exp_issue ? 32'hF : 32'h0);
      if (exp_issue) chk("imem_addr", imem_addr, {fetch_pc[31:2], 2'b00});
      if (imem_rmask == 4'hF) n_issue++;
      if (request_new_inst) n_pulse++;
      if (out_valid && out_ready) begin
        n_pop++;
        pop_pc_q.push_back(out_pc);
        last_pop_cyc = cyc;
      end
    end
    nxt_pc   = pc;
    was_resp = imem_resp;
    @(posedge clk);
    #1;
    pc_reg = nxt_pc;
    if (!rst_n) begin
      exp_q.delete();
      m_out = 0; m_killed = 0;
    end else if (flush) begin
      exp_q.delete();
      if (m_out) begin
        if (was_resp) m_out = 0;
        else m_killed = 1;
      end
    end else begin
      if (exp_pop) void'(exp_q.pop_front());
      if (was_resp && m_out) begin
        if (exp_pulse) exp_q.push_back({m_req_addr, mem_word(m_req_addr)});
        m_out = 0; m_killed = 0;
      end
      if (exp_issue) begin
        m_out = 1; m_killed = 0;
        m_req_addr = {fetch_pc[31:2], 2'b00};
      end
      if (exp_q.size() > DEPTH) chk("model_overflow", exp_q.size(), DEPTH);
    end
    if (was_resp) mem_busy = 0;
    if (s_rmask == 4'hF) begin
      mem_busy = 1;
      mem_addr = s_addr;
      mem_cnt  = (lat_cfg == 0) ? int'($urandom_range(1, 3)) : lat_cfg;
    end
    cyc++;
  endtask

  task automatic do_reset(input logic [31:0] start_pc);
    pc_reg = start_pc;
    rst_n  = 1'b0;
    flush  = 1'b0;
    repeat (2) tick();
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_inst", out_inst, 32'h0);
    mem_busy = 0;
    rst_n = 1'b1;
    cyc = 0; n_issue = 0; n_pulse = 0; n_pop = 0; last_pop_cyc = -1;
    pop_pc_q.delete();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] start_pc;
    int          lat;
    int          n;
    int          exp_cyc;   // cycle (from reset release) of the n-th pop
  } vec_t;
  vec_t vecs[3];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int guard;
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; redirect_pc = 32'h0;
    imem_resp = 1'b0; imem_rdata = 32'h0; pc_reg = 32'h0;
    mem_busy = 0; mem_cnt = 0; mem_addr = 32'h0; lat_cfg = 1;
    m_out = 0; m_killed = 0; m_req_addr = 32'h0;
    #1;

    vecs[0] = '{32'h6000_0000, 1, 8, 9};
    vecs[1] = '{32'h6000_0100, 2, 5, 11};
    vecs[2] = '{32'h0000_1000, 3, 4, 13};

    // Streaming after reset, several memory latencies.
    for (int i = 0; i < 3; i++) begin
      lat_cfg = vecs[i].lat;
      out_ready = 1'b1;
      do_reset(vecs[i].start_pc);
      guard = 0;
      while (pop_pc_q.size() < vecs[i].n && guard < 200) begin
        tick();
        guard++;
      end
      chk("tbl_npop", pop_pc_q.size(), vecs[i].n);
      chk("tbl_last_cyc", last_pop_cyc, vecs[i].exp_cyc);
      for (int k = 0; k < pop_pc_q.size(); k++) begin
        v = vecs[i].start_pc + 32'(4 * k);
        chk("tbl_pc", pop_pc_q[k], v);
      end
    end

    // FIFO full: exactly DEPTH accepted, one pop frees exactly one request.
    lat_cfg = 1; out_ready = 1'b0;
    do_reset(32'h6000_0400);
    repeat (20) tick();
    chk("full_issues", n_issue, DEPTH);
    chk("full_valid", {31'h0, out_valid}, 32'h1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    repeat (10) tick();
    chk("full_issues_after_pop", n_issue, DEPTH + 1);
    chk("full_pops", n_pop, 1);

    // Flush during WAIT, one cycle before the response.
    lat_cfg = 2; out_ready = 1'b1;
    do_reset(32'h6000_0010);
    tick();
    flush = 1'b1; redirect_pc = 32'h6000_0100;
    tick();
    flush = 1'b0;
    tick();
    chk("flushw_pulses", n_pulse, 0);
    chk("flushw_issues", n_issue, 1);
    tick();
    chk("flushw_rmask", {28'h0, s_rmask}, 32'hF);
    chk("flushw_addr", s_addr, 32'h6000_0100);
    chk("flushw_valid", {31'h0, s_valid}, 32'h0);

    // Flush coincident with a response while the FIFO holds 3 entries.
    lat_cfg = 1; out_ready = 1'b0;
    do_reset(32'h6000_0020);
    repeat (4) tick();
    chk("flushr_pre_valid", {31'h0, out_valid}, 32'h1);
    n_pulse = 0;
    flush = 1'b1; redirect_pc = 32'h6000_0200;
    tick();
    flush = 1'b0;
    tick();
    chk("flushr_pulses", n_pulse, 0);
    chk("flushr_valid", {31'h0, s_valid}, 32'h0);
    chk("flushr_rmask", {28'h0, s_rmask}, 32'hF);
    chk("flushr_addr", s_addr, 32'h6000_0200);

    // Reset while a request is outstanding; response lands during reset.
    lat_cfg = 2; out_ready = 1'b1;
    do_reset(32'h6000_0300);
    tick();
    n_pulse = 0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rstw_pulses", n_pulse, 0);
    chk("rstw_rmask", {28'h0, s_rmask}, 32'hF);
    chk("rstw_addr", s_addr, 32'h6000_0300);
    chk("rstw_valid", {31'h0, s_valid}, 32'h0);

    // Randomized traffic against the reference model.
    lat_cfg = 0;
    do_reset(32'h6000_0000);
    for (int ph = 0; ph < 3; ph++) begin
      for (int c = 0; c < 600; c++) begin
        out_ready   = ($urandom_range(0, 3) < ph + 1);
        flush       = ($urandom_range(0, 29) == 0);
        redirect_pc = 32'h6000_0000 + (32'($urandom_range(0, 1023)) << 2);
        tick();
      end
    end
    flush = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
